// File: rtl/spi_frame_decoder.sv
// SPI command frame decoder for the inverter control port.
// Frames are HEADER, CMD, DATA, CSUM. Writes update the control registers
// and reads return a register (or live status) on the next SPI transfer.
// tx_byte carries the response for the byte the master shifts next.
module spi_frame_decoder #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic [7:0] status_in,
    output logic [7:0] tx_byte,
    output logic [7:0] ctrl_reg,
    output logic [7:0] duty_reg,
    output logic [7:0] freq_reg,
    output logic       frame_ok,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    localparam logic [7:0] RESP_ACK = 8'h01;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    state_t      state;
    logic        rx_valid_p0;
    logic        strb_p1;
    logic [7:0]  byte_p1;
    logic [7:0]  csum_acc;
    logic [7:0]  cmd_byte;
    logic [7:0]  data_byte;
    logic [15:0] tmo_cnt;

    // Running checksum: 8-bit add that wraps on overflow.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        csum_add = acc + b;
    endfunction

    // Read-back mux; address 3 is the live status input.
    function automatic logic [7:0] read_data(input logic [1:0] addr,
                                             input logic [7:0] c,
                                             input logic [7:0] d,
                                             input logic [7:0] f,
                                             input logic [7:0] s);
        case (addr)
            2'd0:    read_data = c;
            2'd1:    read_data = d;
            2'd2:    read_data = f;
            default: read_data = s;
        endcase
    endfunction

    // Stage p0 -> p1: rising-edge detect on rx_valid, byte captured with the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid_p0 <= 1'b0;
            strb_p1     <= 1'b0;
            byte_p1     <= 8'h00;
        end else begin
            rx_valid_p0 <= rx_valid;
            strb_p1     <= rx_valid & ~rx_valid_p0;
            byte_p1     <= rx_byte;
        end
    end

    // Stage p1 -> outputs: frame FSM, checksum, timeout and registered responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx_byte   <= 8'h00;
            ctrl_reg  <= 8'h00;
            duty_reg  <= 8'h00;
            freq_reg  <= 8'h00;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            csum_acc  <= 8'h00;
            cmd_byte  <= 8'h00;
            data_byte <= 8'h00;
            tmo_cnt   <= 16'd0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (strb_p1) begin
                // A strobe always wins over a coincident timeout.
                tmo_cnt <= 16'd0;
                case (state)
                    IDLE: begin
                        if (byte_p1 == HEADER) begin
                            state    <= CMD;
                            csum_acc <= byte_p1;
                            tx_byte  <= 8'h00;
                        end
                    end
                    CMD: begin
                        state    <= DATA;
                        csum_acc <= csum_add(csum_acc, byte_p1);
                        cmd_byte <= byte_p1;
                        tx_byte  <= byte_p1[7] ?
                                    read_data(byte_p1[1:0], ctrl_reg, duty_reg, freq_reg, status_in) :
                                    8'h00;
                    end
                    DATA: begin
                        state     <= CSUM;
                        csum_acc  <= csum_add(csum_acc, byte_p1);
                        data_byte <= byte_p1;
                        tx_byte   <= 8'h00;
                    end
                    default: begin
                        state <= IDLE;
                        // Status (address 3) is read-only; writing it is a frame error.
                        if ((csum_acc == byte_p1) && (cmd_byte[7] || (cmd_byte[1:0] != 2'd3))) begin
                            frame_ok <= 1'b1;
                            tx_byte  <= RESP_ACK;
                            if (!cmd_byte[7]) begin
                                case (cmd_byte[1:0])
                                    2'd0:    ctrl_reg <= data_byte;
                                    2'd1:    duty_reg <= data_byte;
                                    2'd2:    freq_reg <= data_byte;
                                    default: ;
                                endcase
                            end
                        end else begin
                            frame_err <= 1'b1;
                            tx_byte   <= RESP_NAK;
                        end
                    end
                endcase
            end else if (state == IDLE) begin
                tmo_cnt <= 16'd0;
            end else if (tmo_cnt == TIMEOUT) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                tx_byte   <= 8'h00;
                tmo_cnt   <= 16'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder: write/read frames, checksum and
// address errors, inter-byte timeout, noise with wide rx_valid, mid-frame reset.
module tb_spi_frame_decoder;

    localparam logic [7:0]  HDR = 8'hA5;
    localparam logic [15:0] TMO = 16'd40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] status_in;
    logic [7:0] tx_byte;
    logic [7:0] ctrl_reg;
    logic [7:0] duty_reg;
    logic [7:0] freq_reg;
    logic       frame_ok;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int ok0;
    int err0;

    spi_frame_decoder #(.HEADER(HDR), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .status_in (status_in),
        .tx_byte   (tx_byte),
        .ctrl_reg  (ctrl_reg),
        .duty_reg  (duty_reg),
        .freq_reg  (freq_reg),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_cnt++;
        if (frame_ok && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int width);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        repeat (width) @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic mark();
        ok0  = ok_cnt;
        err0 = err_cnt;
    endtask

    initial begin
        rst       = 1'b0;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        status_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx",   tx_byte,   8'h00);
        check("rst_ctrl", ctrl_reg,  8'h00);
        check("rst_duty", duty_reg,  8'h00);
        check("rst_freq", freq_reg,  8'h00);
        check("rst_ok",   frame_ok,  1'b0);
        check("rst_err",  frame_err, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Write duty
        mark();
        send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h80, 1); send_byte(8'h26, 1);
        check("wr_duty",     duty_reg, 8'h80);
        check("wr_duty_ok",  ok_cnt - ok0, 1);
        check("wr_duty_err", err_cnt - err0, 0);
        check("wr_duty_tx",  tx_byte, 8'h01);
        check("wr_duty_ctrl", ctrl_reg, 8'h00);
        check("wr_duty_freq", freq_reg, 8'h00);

        // Read status
        status_in = 8'h3C;
        mark();
        send_byte(8'hA5, 1);
        send_byte(8'h83, 1);
        check("rd_st_cmd_tx",  tx_byte, 8'h3C);
        send_byte(8'h00, 1);
        check("rd_st_data_tx", tx_byte, 8'h00);
        send_byte(8'h28, 1);
        check("rd_st_csum_tx", tx_byte, 8'h01);
        check("rd_st_ok",      ok_cnt - ok0, 1);
        check("rd_st_duty",    duty_reg, 8'h80);

        // Read duty register back
        send_byte(8'hA5, 1);
        send_byte(8'h81, 1);
        check("rd_duty_cmd_tx", tx_byte, 8'h80);
        send_byte(8'h00, 1); send_byte(8'h26, 1);
        check("rd_duty_tx", tx_byte, 8'h01);

        // Bad checksum
        mark();
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h10, 1); send_byte(8'h00, 1);
        check("bad_cs_freq", freq_reg, 8'h00);
        check("bad_cs_err",  err_cnt - err0, 1);
        check("bad_cs_ok",   ok_cnt - ok0, 0);
        check("bad_cs_tx",   tx_byte, 8'hEE);

        // Write to read-only status address
        mark();
        send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h55, 1); send_byte(8'hFD, 1);
        check("wr_st_err",  err_cnt - err0, 1);
        check("wr_st_ok",   ok_cnt - ok0, 0);
        check("wr_st_tx",   tx_byte, 8'hEE);
        check("wr_st_ctrl", ctrl_reg, 8'h00);
        check("wr_st_duty", duty_reg, 8'h80);
        check("wr_st_freq", freq_reg, 8'h00);

        // Timeout mid-frame, then a good frame
        mark();
        send_byte(8'hA5, 1); send_byte(8'h01, 1);
        repeat (20) @(negedge clk);
        check("tmo_early", err_cnt - err0, 0);
        for (int i = 0; i < 200 && err_cnt == err0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("tmo_err", err_cnt - err0, 1);
        check("tmo_tx",  tx_byte, 8'h00);
        check("tmo_duty", duty_reg, 8'h80);
        mark();
        send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h07, 1); send_byte(8'hAC, 1);
        check("post_tmo_ctrl", ctrl_reg, 8'h07);
        check("post_tmo_ok",   ok_cnt - ok0, 1);

        // Noise byte and wide rx_valid
        mark();
        send_byte(8'h12, 3); send_byte(8'hA5, 3); send_byte(8'h00, 3);
        send_byte(8'h01, 3); send_byte(8'hA6, 3);
        check("wide_ctrl", ctrl_reg, 8'h01);
        check("wide_ok",   ok_cnt - ok0, 1);
        check("wide_err",  err_cnt - err0, 0);

        // Reset mid-frame
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h33, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_ctrl", ctrl_reg, 8'h00);
        check("mid_rst_duty", duty_reg, 8'h00);
        check("mid_rst_freq", freq_reg, 8'h00);
        check("mid_rst_tx",   tx_byte,  8'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mark();
        send_byte(8'hDA, 1);
        check("mid_rst_nopulse_ok",  ok_cnt - ok0, 0);
        check("mid_rst_nopulse_err", err_cnt - err0, 0);
        check("mid_rst_freq2",       freq_reg, 8'h00);
        send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h33, 1); send_byte(8'hDA, 1);
        check("post_rst_freq", freq_reg, 8'h33);
        check("post_rst_ok",   ok_cnt - ok0, 1);

        check("never_both", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_decoder.md
SPI_FRAME_DECODER -- requirements
Module: spi_frame_decoder

Interface
REQ-001 The block SHALL have parameter HEADER, default 8'hA5, the frame start byte.
REQ-002 The block SHALL have parameter TIMEOUT, default 16'd50000, the inter-byte timeout in clk cycles.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 rx_byte  input  8  received byte from the SPI slave.
REQ-006 rx_valid  input  1  byte-complete flag from the SPI slave; may stay high for one or more cycles.
REQ-007 status_in  input  8  live inverter status, readable at address 3.
REQ-008 tx_byte  output  8  byte the SPI slave shifts out on the next transfer.
REQ-009 ctrl_reg  output  8  register at address 0 (inverter control).
REQ-010 duty_reg  output  8  register at address 1 (PWM duty).
REQ-011 freq_reg  output  8  register at address 2 (output frequency).
REQ-012 frame_ok  output  1  one-cycle pulse when a frame is accepted.
REQ-013 frame_err  output  1  one-cycle pulse on checksum error, illegal write or timeout.

Function
REQ-014 A byte strobe SHALL be the rising edge of rx_valid, detected against a one-cycle-delayed copy; exactly one strobe per byte, regardless of how long rx_valid stays high.
REQ-015 A frame SHALL be 4 bytes: HEADER, CMD, DATA, CSUM.
  - CMD[7]=1 means read, 0 means write.
  - CMD[1:0] is the address; CMD[6:2] are ignored.
REQ-016 CSUM SHALL equal (HEADER + CMD + DATA) mod 256, computed in an 8-bit accumulator that wraps on overflow.
REQ-017 State machine states SHALL be IDLE, CMD, DATA, CSUM; each transition happens on a strobe.
  - IDLE->CMD when rx_byte==HEADER; any other byte keeps IDLE, no error.
  - CMD->DATA and DATA->CSUM unconditionally.
  - CSUM->IDLE after evaluating the frame.
REQ-018 On the CMD strobe, tx_byte SHALL load the read data for CMD[1:0] if CMD[7]=1 (ctrl/duty/freq/status_in sampled at that cycle), else 8'h00.
REQ-019 On the HEADER and DATA strobes, tx_byte SHALL load 8'h00.
REQ-020 On the CSUM strobe with a matching checksum:
  - write to address 0-2: update the addressed register on that clock edge, pulse frame_ok, tx_byte=8'h01;
  - read: pulse frame_ok, tx_byte=8'h01.
REQ-021 On the CSUM strobe, a checksum mismatch or a write to address 3 SHALL leave all registers unchanged, pulse frame_err and set tx_byte=8'hEE.
REQ-022 A 16-bit timeout counter SHALL clear on every strobe and in IDLE, and otherwise increment in CMD/DATA/CSUM.
REQ-023 When the timeout counter reaches TIMEOUT, the block SHALL return to IDLE, pulse frame_err, set tx_byte=8'h00 and clear the counter.
REQ-024 If a strobe and a timeout occur in the same cycle, the strobe SHALL win: normal transition, counter cleared, no frame_err.
REQ-025 frame_ok and frame_err SHALL each be high for exactly one cycle and SHALL never both be high.
REQ-026 Latency SHALL be two clk cycles from the rx_valid rise to register/tx_byte/pulse update: one cycle for edge detect, one for the registered update.

Reset
REQ-027 While rst is low, state SHALL be IDLE, and tx_byte, ctrl_reg, duty_reg, freq_reg, the checksum accumulator, the timeout counter and the edge-detect register SHALL be 0; frame_ok and frame_err SHALL be 0.
REQ-028 A reset asserted mid-frame SHALL abort the frame with no register update and no pulse; the first strobe after release is treated as a possible HEADER.

Verification
REQ-029 Write duty: bytes A5,01,80,26 -> duty_reg=8'h80, frame_ok one pulse, tx_byte=8'h01; ctrl_reg and freq_reg remain 0.
REQ-030 Read status with status_in=8'h3C: bytes A5,83,00,28 -> tx_byte=8'h3C after the CMD strobe, 8'h00 after DATA, 8'h01 after CSUM; frame_ok pulses; no register change.
REQ-031 Bad checksum: bytes A5,02,10,00 -> freq_reg unchanged at 0, frame_err one pulse, tx_byte=8'hEE.
REQ-032 Write to status: bytes A5,03,55,FD -> frame_err pulse, tx_byte=8'hEE, no register change.
REQ-033 Timeout: send A5,01, then hold TIMEOUT cycles -> frame_err pulse, state IDLE; then A5,00,07,AC -> ctrl_reg=8'h07.
REQ-034 Noise and rx_valid width: bytes 12,A5,00,01,A6 with rx_valid held high 3 cycles per byte -> ctrl_reg=8'h01, exactly one frame_ok, no frame_err.
